// File: rtl/control_pkg.sv
// Shared constants, control-word layout and FSM state type for the
// control_pipe decode/issue stage.
package control_pkg;

    localparam logic [5:0] OP_RTYPE_OFS = 6'd0;
    localparam logic [5:0] OP_LOAD_OFS  = 6'd1;
    localparam logic [5:0] OP_STORE_OFS = 6'd2;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_MUL = 6'd50;

    localparam logic [4:0] SHAMT_TAG = 5'd10;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    // Upper part of Controle, MSB first; Rs/Rt/Rd follow below it.
    typedef struct packed {
        logic    rw;
        alu_op_e op;
        logic    off;
        logic    mux_in;
        logic    mux_out;
        logic    mux_wb;
        logic    wr;
        logic    mult;
    } ctrl_fields_t;

    localparam int CF_W = 9;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_MBUSY = 2'd2
    } state_e;

    function automatic int ctrl_width(input int reg_bits);
        return CF_W + 3 * reg_bits;
    endfunction

    function automatic int fields_lsb(input int reg_bits);
        return 3 * reg_bits;
    endfunction

    function automatic ctrl_fields_t rtype_fields(input alu_op_e op, input logic mult);
        ctrl_fields_t f;
        f         = '0;
        f.rw      = 1'b1;
        f.op      = op;
        f.mux_out = ~mult;
        f.wr      = 1'b1;
        f.mult    = mult;
        return f;
    endfunction

    function automatic ctrl_fields_t mem_fields(input logic is_load);
        ctrl_fields_t f;
        f         = '0;
        f.rw      = is_load;
        f.op      = ALU_ADD;
        f.off     = 1'b1;
        f.mux_in  = 1'b1;
        f.mux_out = 1'b1;
        f.mux_wb  = 1'b1;
        f.wr      = is_load;
        f.mult    = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Fetch-to-decode handshake: instruction in, stall back, registered control out.
interface control_pipe_if #(
    parameter int CTRL_W = 24
);
    logic [31:0]       Instrucao;
    logic              instr_valid;
    logic              stall;
    logic [CTRL_W-1:0] Controle;
    logic              ctrl_valid;
    logic              illegal;

    modport master (
        output Instrucao, instr_valid,
        input  stall, Controle, ctrl_valid, illegal
    );

    modport slave (
        input  Instrucao, instr_valid,
        output stall, Controle, ctrl_valid, illegal
    );
endinterface

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: fields, load/mul tags and legality.
module control_decode
    import control_pkg::*;
#(
    parameter int GRUPO    = 4,
    parameter int REG_BITS = 5
) (
    input  logic [31:0]         instr,
    output ctrl_fields_t        fields,
    output logic [REG_BITS-1:0] rs,
    output logic [REG_BITS-1:0] rt,
    output logic [REG_BITS-1:0] rd,
    output logic                is_load,
    output logic                is_mul,
    output logic                illegal
);
    logic [5:0] opcode_s;
    logic [5:0] base_s;

    assign opcode_s = instr[31:26];
    assign base_s   = 6'(GRUPO);

    // Opcode/funct decode; anything not matched stays illegal with zero fields.
    always_comb begin
        fields  = '0;
        rd      = '0;
        is_load = 1'b0;
        is_mul  = 1'b0;
        illegal = 1'b1;
        rs      = REG_BITS'(instr[25:21]);
        rt      = REG_BITS'(instr[20:16]);
        if (opcode_s == base_s + OP_LOAD_OFS) begin
            fields  = mem_fields(1'b1);
            rd      = REG_BITS'(instr[20:16]);
            is_load = 1'b1;
            illegal = 1'b0;
        end else if (opcode_s == base_s + OP_STORE_OFS) begin
            fields  = mem_fields(1'b0);
            illegal = 1'b0;
        end else if ((opcode_s == base_s + OP_RTYPE_OFS) && (instr[10:6] == SHAMT_TAG)) begin
            rd      = REG_BITS'(instr[15:11]);
            illegal = 1'b0;
            case (instr[5:0])
                FUNCT_ADD: fields = rtype_fields(ALU_ADD, 1'b0);
                FUNCT_SUB: fields = rtype_fields(ALU_SUB, 1'b0);
                FUNCT_AND: fields = rtype_fields(ALU_AND, 1'b0);
                FUNCT_OR:  fields = rtype_fields(ALU_OR, 1'b0);
                FUNCT_MUL: begin
                    fields = rtype_fields(ALU_ADD, 1'b1);
                    is_mul = 1'b1;
                end
                default: begin
                    rd      = '0;
                    illegal = 1'b1;
                end
            endcase
        end else begin
            illegal = 1'b1;
        end
    end
endmodule

// File: rtl/control_pipe.sv
// Registered instruction-control stage: decode plus load-use interlock,
// multiplier busy window and illegal-instruction flagging.
module control_pipe
    import control_pkg::*;
#(
    parameter int GRUPO    = 4,
    parameter int MUL_LAT  = 3,
    parameter int REG_BITS = 5,
    parameter int CTRL_W   = 9 + 3 * REG_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    control_pipe_if.slave  bus
);
    localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_LAT - 1);
    localparam bit HAS_WINDOW = (MUL_LAT > 1) ? 1'b1 : 1'b0;

    state_e              state_r, state_s;
    logic [MCNT_W-1:0]   mcnt_r, mcnt_s;
    logic                ld_vld_r;
    logic [REG_BITS-1:0] ld_rd_r;
    logic [CTRL_W-1:0]   ctrl_r;
    logic                ctrl_valid_r;
    logic                illegal_r;

    ctrl_fields_t        dec_fields_s;
    logic [REG_BITS-1:0] dec_rs_s, dec_rt_s, dec_rd_s;
    logic                dec_is_load_s, dec_is_mul_s, dec_illegal_s;
    logic                hazard_s, busy_s, issue_s, flag_illegal_s, stall_s;

    control_decode #(.GRUPO(GRUPO), .REG_BITS(REG_BITS)) u_decode (
        .instr   (bus.Instrucao),
        .fields  (dec_fields_s),
        .rs      (dec_rs_s),
        .rt      (dec_rt_s),
        .rd      (dec_rd_s),
        .is_load (dec_is_load_s),
        .is_mul  (dec_is_mul_s),
        .illegal (dec_illegal_s)
    );

    // Stall/issue decisions; illegal instructions are consumed without stalling.
    always_comb begin
        hazard_s = 1'b0;
        busy_s   = 1'b0;
        if (bus.instr_valid && !dec_illegal_s) begin
            busy_s   = (state_r == ST_MBUSY);
            hazard_s = (state_r == ST_RUN) && ld_vld_r &&
                       ((dec_rs_s == ld_rd_r) || (dec_rt_s == ld_rd_r));
        end else begin
            busy_s   = 1'b0;
            hazard_s = 1'b0;
        end
        issue_s        = bus.instr_valid && !dec_illegal_s && !busy_s && !hazard_s;
        flag_illegal_s = bus.instr_valid && dec_illegal_s;
        stall_s        = rst_n && (busy_s || hazard_s);
    end

    // Next state and multiplier countdown.
    always_comb begin
        state_s = state_r;
        mcnt_s  = mcnt_r;
        case (state_r)
            ST_RUN, ST_LU: begin
                if (hazard_s) begin
                    state_s = ST_LU;
                end else if (issue_s && dec_is_mul_s && HAS_WINDOW) begin
                    state_s = ST_MBUSY;
                    mcnt_s  = MCNT_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_MBUSY: begin
                if (mcnt_r <= MCNT_W'(1)) begin
                    state_s = ST_RUN;
                    mcnt_s  = '0;
                end else begin
                    mcnt_s  = mcnt_r - MCNT_W'(1);
                end
            end
            default: begin
                state_s = ST_RUN;
                mcnt_s  = '0;
            end
        endcase
    end

    // State, load tracking and output registers; a bubble clears load tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            mcnt_r       <= '0;
            ld_vld_r     <= 1'b0;
            ld_rd_r      <= '0;
            ctrl_r       <= '0;
            ctrl_valid_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            mcnt_r       <= mcnt_s;
            ld_vld_r     <= issue_s && dec_is_load_s && (dec_rd_s != '0);
            ld_rd_r      <= dec_rd_s;
            ctrl_valid_r <= issue_s;
            illegal_r    <= flag_illegal_s;
            ctrl_r       <= issue_s ? CTRL_W'({dec_fields_s, dec_rs_s, dec_rt_s, dec_rd_s})
                                    : '0;
        end
    end

    assign bus.stall      = stall_s;
    assign bus.Controle   = ctrl_r;
    assign bus.ctrl_valid = ctrl_valid_r;
    assign bus.illegal    = illegal_r;
endmodule

// File: tb/tb_control_pipe.sv
// Directed self-checking bench for control_pipe (MUL_LAT=3 and MUL_LAT=1 instances).
module tb_control_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADD   = 32'h10221AA0;
    localparam logic [31:0] I_SUB   = 32'h10221AA2;
    localparam logic [31:0] I_AND   = 32'h10221AA4;
    localparam logic [31:0] I_OR    = 32'h10221AA5;
    localparam logic [31:0] I_SH9   = 32'h10221A60;
    localparam logic [31:0] I_LOAD  = 32'h14250004;
    localparam logic [31:0] I_ADD5  = 32'h10A232A0;
    localparam logic [31:0] I_STORE = 32'h18050008;
    localparam logic [31:0] I_MUL   = 32'h10223AB2;
    localparam logic [31:0] I_BAD   = 32'hFC000000;

    localparam logic [23:0] C_ADD   = 24'h850443;
    localparam logic [23:0] C_SUB   = 24'hA50443;
    localparam logic [23:0] C_AND   = 24'hC50443;
    localparam logic [23:0] C_OR    = 24'hE50443;
    localparam logic [23:0] C_LOAD  = 24'h9F04A5;
    localparam logic [23:0] C_ADD5  = 24'h851446;
    localparam logic [23:0] C_STORE = 24'h1E00A0;
    localparam logic [23:0] C_MUL   = 24'h818447;

    always #5 clk = ~clk;

    control_pipe_if #(.CTRL_W(24)) bus3 ();
    control_pipe_if #(.CTRL_W(24)) bus1 ();

    control_pipe #(.GRUPO(4), .MUL_LAT(3), .REG_BITS(5), .CTRL_W(24)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );
    control_pipe #(.GRUPO(4), .MUL_LAT(1), .REG_BITS(5), .CTRL_W(24)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v);
        bus3.Instrucao   = ins;
        bus3.instr_valid = v;
        bus1.Instrucao   = ins;
        bus1.instr_valid = v;
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(I_ADD, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus3.stall !== 1'b0) begin
                errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", i, bus3.stall);
            end
            tick();
            checks++;
            if (bus3.Controle !== 24'h0 || bus3.ctrl_valid !== 1'b0 || bus3.illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_out[%0d]: got ctrl=%h v=%b ill=%b expected 0/0/0",
                         i, bus3.Controle, bus3.ctrl_valid, bus3.illegal);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(I_ADD, 1'b1);
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL add_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== C_ADD || bus3.ctrl_valid !== 1'b1 || bus3.illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_out: got ctrl=%h v=%b ill=%b expected %h/1/0",
                     bus3.Controle, bus3.ctrl_valid, bus3.illegal, C_ADD);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [23:0] exp [3];
        ins = '{I_SUB, I_AND, I_OR};
        exp = '{C_SUB, C_AND, C_OR};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b1);
            checks++;
            if (bus3.stall !== 1'b0) begin
                errors++; $display("FAIL b2b_stall[%0d]: got %b expected 0", i, bus3.stall);
            end
            tick();
            checks++;
            if (bus3.Controle !== exp[i] || bus3.ctrl_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got ctrl=%h v=%b expected %h/1",
                         i, bus3.Controle, bus3.ctrl_valid, exp[i]);
            end
        end
        drive(I_SH9, 1'b1);
        tick();
        checks++;
        if (bus3.illegal !== 1'b1 || bus3.ctrl_valid !== 1'b0 || bus3.Controle !== 24'h0) begin
            errors++;
            $display("FAIL shamt_illegal: got ill=%b v=%b ctrl=%h expected 1/0/000000",
                     bus3.illegal, bus3.ctrl_valid, bus3.Controle);
        end
    endtask

    task automatic test_load_use();
        drive(I_LOAD, 1'b1);
        tick();
        checks++;
        if (bus3.Controle !== C_LOAD || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL load_out: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_LOAD);
        end
        drive(I_ADD5, 1'b1);
        checks++;
        if (bus3.stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got %b expected 1", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.ctrl_valid !== 1'b0 || bus3.Controle !== 24'h0) begin
            errors++; $display("FAIL lu_bubble: got %h/%b expected 000000/0", bus3.Controle, bus3.ctrl_valid);
        end
        #2;
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL lu_second_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== C_ADD5 || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL lu_issue: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_ADD5);
        end
        // Store data register (Rt) also counts as a consumer of the load.
        drive(I_LOAD, 1'b1);
        tick();
        drive(I_STORE, 1'b1);
        checks++;
        if (bus3.stall !== 1'b1) begin
            errors++; $display("FAIL store_stall: got %b expected 1", bus3.stall);
        end
        tick();
        tick();
        checks++;
        if (bus3.Controle !== C_STORE || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL store_issue: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_STORE);
        end
        // An idle cycle between load and consumer clears the tracking.
        drive(I_LOAD, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        tick();
        drive(I_ADD5, 1'b1);
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL idle_clears_lu: got %b expected 0", bus3.stall);
        end
        tick();
    endtask

    task automatic test_mul_busy();
        drive(I_MUL, 1'b1);
        tick();
        checks++;
        if (bus3.Controle !== C_MUL || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL mul_out: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_MUL);
        end
        drive(I_ADD, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus3.stall !== 1'b1) begin
                errors++; $display("FAIL mul_stall[%0d]: got %b expected 1", i, bus3.stall);
            end
            tick();
            checks++;
            if (bus3.ctrl_valid !== 1'b0) begin
                errors++; $display("FAIL mul_bubble[%0d]: got v=%b expected 0", i, bus3.ctrl_valid);
            end
            #2;
        end
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL mul_window_end: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== C_ADD || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL mul_then_add: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_ADD);
        end
        drive(I_SUB, 1'b1);
        tick();
        checks++;
        if (bus3.Controle !== C_SUB || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL mul_then_sub: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_SUB);
        end
    endtask

    task automatic test_mul_lat1();
        logic [31:0] ins [3];
        logic [23:0] exp [3];
        ins = '{I_MUL, I_ADD, I_SUB};
        exp = '{C_MUL, C_ADD, C_SUB};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b1);
            checks++;
            if (bus1.stall !== 1'b0) begin
                errors++; $display("FAIL lat1_stall[%0d]: got %b expected 0", i, bus1.stall);
            end
            tick();
            checks++;
            if (bus1.Controle !== exp[i] || bus1.ctrl_valid !== 1'b1) begin
                errors++;
                $display("FAIL lat1_out[%0d]: got %h/%b expected %h/1", i, bus1.Controle, bus1.ctrl_valid, exp[i]);
            end
        end
        drive(32'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_illegal();
        drive(I_BAD, 1'b1);
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL illegal_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.illegal !== 1'b1 || bus3.ctrl_valid !== 1'b0 || bus3.Controle !== 24'h0) begin
            errors++;
            $display("FAIL illegal_out: got ill=%b v=%b ctrl=%h expected 1/0/000000",
                     bus3.illegal, bus3.ctrl_valid, bus3.Controle);
        end
        drive(I_ADD, 1'b1);
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL illegal_next_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== C_ADD || bus3.ctrl_valid !== 1'b1 || bus3.illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_then_add: got %h/%b/%b expected %h/1/0",
                     bus3.Controle, bus3.ctrl_valid, bus3.illegal, C_ADD);
        end
    endtask

    task automatic test_reset_mid_mbusy();
        drive(I_MUL, 1'b1);
        tick();
        drive(I_ADD, 1'b1);
        checks++;
        if (bus3.stall !== 1'b1) begin
            errors++; $display("FAIL rmb_busy_stall: got %b expected 1", bus3.stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL rmb_forced_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== 24'h0 || bus3.ctrl_valid !== 1'b0) begin
            errors++; $display("FAIL rmb_clear: got %h/%b expected 000000/0", bus3.Controle, bus3.ctrl_valid);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus3.stall !== 1'b0) begin
            errors++; $display("FAIL rmb_after_stall: got %b expected 0", bus3.stall);
        end
        tick();
        checks++;
        if (bus3.Controle !== C_ADD || bus3.ctrl_valid !== 1'b1) begin
            errors++; $display("FAIL rmb_after_issue: got %h/%b expected %h/1", bus3.Controle, bus3.ctrl_valid, C_ADD);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_load_use();
        test_mul_busy();
        test_mul_lat1();
        test_illegal();
        test_reset_mid_mbusy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
